// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions used by the fetch stage and the branch control unit:
//   - pcsrc_e     : PC-source select codes driven by EX
//   - fsm_state_e : fetch sequencing states (run / debug halt / misalign trap)
//   - NOP_INSTR   : bubble instruction (ADDI x0,x0,0)
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ  = 2'b00,  // PC + 4
        PCSRC_BR   = 2'b01,  // PC + Imm (branch / JAL)
        PCSRC_JALR = 2'b10,  // rs1 + Imm (JALR)
        PCSRC_RSVD = 2'b11   // unused code, behaves as PCSRC_SEQ
    } pcsrc_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_TRAP = 2'b10
    } fsm_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_redirect_unit_if
// Synchronous instruction-memory port between the fetch stage and the imem.
//   imem_addr : fetch address (fetch PC register)
//   imem_en   : read enable; when low the memory holds its output register
//   imem_data : registered read data, valid one cycle after an enabled read
// Modports: master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_redirect_unit_if #(
    parameter int unsigned NB_PC    = 32,
    parameter int unsigned NB_INSTR = 32
);

    logic [NB_PC-1:0]    imem_addr;
    logic                imem_en;
    logic [NB_INSTR-1:0] imem_data;

    modport master (
        output imem_addr,
        output imem_en,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        input  imem_en,
        output imem_data
    );

endinterface

// File: rtl/fetch_redirect_unit_pc_next_mux.sv
// -----------------------------------------------------------------------------
// pc_next_mux
// Combinational next-PC selection for the fetch stage.
//   i_pc            : current fetch PC
//   i_pcSrc         : PC-source select from EX (cpu_pkg::pcsrc_e encoding)
//   i_flush         : redirect request from EX
//   i_branch_target : PC + Imm target
//   i_jalr_target   : raw rs1 + Imm target
//   o_pc_seq        : i_pc + 4 (wraps modulo 2^NB_PC)
//   o_target        : effective redirect target
//   o_misaligned    : redirect to a target that is not 4-byte aligned
// -----------------------------------------------------------------------------
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter int unsigned NB_PC = 32
) (
    input  logic [NB_PC-1:0] i_pc,
    input  logic [1:0]       i_pcSrc,
    input  logic             i_flush,
    input  logic [NB_PC-1:0] i_branch_target,
    input  logic [NB_PC-1:0] i_jalr_target,
    output logic [NB_PC-1:0] o_pc_seq,
    output logic [NB_PC-1:0] o_target,
    output logic             o_misaligned
);

    logic w_is_jump;

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned; an unassigned path in always_comb infers a latch.
    always_comb begin
        o_pc_seq  = i_pc + NB_PC'(4);
        o_target  = o_pc_seq;
        w_is_jump = 1'b0;
        case (pcsrc_e'(i_pcSrc))
            PCSRC_BR: begin
                o_target  = i_branch_target;
                w_is_jump = 1'b1;
            end
            PCSRC_JALR: begin
                // JALR clears bit 0 of the sum; bit 1 is still checked below.
                o_target  = {i_jalr_target[NB_PC-1:1], 1'b0};
                w_is_jump = 1'b1;
            end
            default: begin
                o_target  = o_pc_seq;
                w_is_jump = 1'b0;
            end
        endcase
        o_misaligned = i_flush && w_is_jump && o_target[1];
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// -----------------------------------------------------------------------------
// fetch_redirect_unit
// Instruction-fetch stage: owns the fetch PC, drives the synchronous imem,
// holds the IF/ID PC/valid register, inserts a NOP bubble on redirects, traps
// on misaligned redirect targets and sequences debug halt.
//   i_clk, i_rst      : clock (rising edge), asynchronous active-high reset
//   i_pcSrc, i_flush  : redirect select / request from EX
//   i_branch_target   : PC + Imm target
//   i_jalr_target     : raw rs1 + Imm target
//   i_stall           : load-use stall (hold everything, no fetch)
//   i_halt            : debug halt request (level)
//   imem              : imem port (address = fetch PC, enable, read data)
//   o_pc, o_pc_plus4  : IF/ID PC and PC + 4
//   o_instr, o_valid  : IF/ID instruction (NOP when not valid) and valid
//   o_halted          : in HALT or TRAP
//   o_misaligned      : sticky misaligned-target trap flag
// -----------------------------------------------------------------------------
module fetch_redirect_unit #(
    parameter int unsigned         NB_PC     = 32,
    parameter int unsigned         NB_INSTR  = 32,
    parameter logic [NB_PC-1:0]    RESET_PC  = '0,
    parameter logic [NB_INSTR-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_pcSrc,
    input  logic                  i_flush,
    input  logic [NB_PC-1:0]      i_branch_target,
    input  logic [NB_PC-1:0]      i_jalr_target,
    input  logic                  i_stall,
    input  logic                  i_halt,
    fetch_redirect_unit_if.master imem,
    output logic [NB_PC-1:0]      o_pc,
    output logic [NB_PC-1:0]      o_pc_plus4,
    output logic [NB_INSTR-1:0]   o_instr,
    output logic                  o_valid,
    output logic                  o_halted,
    output logic                  o_misaligned
);

    import cpu_pkg::*;

    fsm_state_e       r_state;
    fsm_state_e       w_state_next;
    logic [NB_PC-1:0] r_pc;        // fetch PC, address of the read in flight
    logic [NB_PC-1:0] r_if_pc;     // IF/ID PC
    logic             r_valid;     // IF/ID valid
    logic [NB_PC-1:0] w_pc_next;
    logic [NB_PC-1:0] w_if_pc_next;
    logic             w_valid_next;
    logic             w_imem_en;
    logic [NB_PC-1:0] w_pc_seq;
    logic [NB_PC-1:0] w_target;
    logic             w_misaligned;

    pc_next_mux #(.NB_PC(NB_PC)) u_pc_next_mux (
        .i_pc            (r_pc),
        .i_pcSrc         (i_pcSrc),
        .i_flush         (i_flush),
        .i_branch_target (i_branch_target),
        .i_jalr_target   (i_jalr_target),
        .o_pc_seq        (w_pc_seq),
        .o_target        (w_target),
        .o_misaligned    (w_misaligned)
    );

    // Rule priority in RUN: misaligned flush, flush, stall, halt, advance.
    // HALT and TRAP freeze all state; HALT leaves on the first low i_halt and
    // the following RUN cycle re-issues the read at the held fetch PC, so the
    // resumed stream starts with exactly one NOP and loses nothing.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_if_pc_next = r_if_pc;
        w_valid_next = r_valid;
        w_imem_en    = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_imem_en = !i_stall || i_flush;
                if (i_flush && w_misaligned) begin
                    w_state_next = ST_TRAP;
                    w_valid_next = 1'b0;
                end else if (i_flush) begin
                    w_pc_next    = w_target;
                    w_valid_next = 1'b0;
                end else if (i_stall) begin
                    // Hold; the imem keeps its output while disabled.
                end else if (i_halt) begin
                    w_state_next = ST_HALT;
                    w_valid_next = 1'b0;
                end else begin
                    w_if_pc_next = r_pc;
                    w_valid_next = 1'b1;
                    w_pc_next    = w_pc_seq;
                end
            end
            ST_HALT: begin
                if (!i_halt) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_TRAP: begin
                // Left only by reset.
            end
            default: begin
                w_state_next = ST_TRAP;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_if_pc <= RESET_PC;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_if_pc <= w_if_pc_next;
            r_valid <= w_valid_next;
        end
    end

    assign imem.imem_addr = r_pc;
    assign imem.imem_en   = w_imem_en;
    assign o_pc           = r_if_pc;
    assign o_pc_plus4     = r_if_pc + NB_PC'(4);
    assign o_valid        = r_valid;
    assign o_instr        = r_valid ? imem.imem_data : NOP_INSTR;
    assign o_halted       = (r_state != ST_RUN);
    assign o_misaligned   = (r_state == ST_TRAP);

endmodule
